vga_scanout: RTL
================

# vga_scanout

Read side of the 160x120 framebuffer. The game FSM writes pixels into the framebuffer; this block reads them back and drives the DE2 VGA DAC at 640x480 at about 60 Hz. Each logical pixel is replicated 4x4. The block also generates the once-per-frame `frame` tick that paces the game FSM. It sits between the framebuffer RAM read port and the `VGA_*` pins.

## Interface
Parameters:
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_VIS`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch

Ports:
- `clk` in 1: 50 MHz system clock
- `rst` in 1: reset, synchronous, active-low
- `rd_addr` out 15: framebuffer read address, y*160+x
- `rd_data` in 3: framebuffer colour {R,G,B}, valid 1 clk after `rd_addr`
- `frame` out 1: one-clk pulse at start of vertical blanking
- `VGA_CLK` out 1: 25 MHz pixel clock to DAC
- `VGA_HS` out 1: hsync, active-low
- `VGA_VS` out 1: vsync, active-low
- `VGA_BLANK_N` out 1: high during visible area
- `VGA_SYNC_N` out 1: constant 1
- `VGA_R`, `VGA_G`, `VGA_B` out 10 each: DAC colour

## Operation
- **Pixel clock:** `VGA_CLK` is a register that toggles every clk. `pix_en` = (`VGA_CLK`==1).
  - All pixel logic advances only on clk edges where `pix_en`=1, i.e. when `VGA_CLK` falls.
  - DAC inputs are therefore stable for one clk before the `VGA_CLK` rising edge.
- **Counters:** `h_cnt` 10 bits, range 0..799; `v_cnt` 10 bits, range 0..524.
  - On `pix_en`: if `h_cnt`==799, `h_cnt`<=0 and `v_cnt` advances; otherwise `h_cnt`++.
  - `v_cnt` wraps 524->0 on the same edge `h_cnt` wraps.
- **Stage 0 decode** (from counters):
  - visible = `h_cnt`<640 && `v_cnt`<480
  - hs_n = !(656<=`h_cnt`<=751)
  - vs_n = !(490<=`v_cnt`<=491)
- **Address:** on `pix_en` with visible=1, `rd_addr` <= (y<<7)+(y<<5)+x, where x=`h_cnt`[9:2] and y=`v_cnt`[8:2]. No multiplier. When not visible, `rd_addr` holds its value.
- **Stage 1:** on `pix_en`, the block registers visible, hs_n and vs_n into delay flops. It also registers the outputs from `rd_data`, which arrives 1 clk after `rd_addr`, ahead of the next `pix_en`.
  - `VGA_R`={10{c[2]}}, `VGA_G`={10{c[1]}}, `VGA_B`={10{c[0]}}.
  - All colour outputs are 0 whenever the delayed visible flag is 0, regardless of `rd_data`.
  - `VGA_BLANK_N`, `VGA_HS` and `VGA_VS` come from the delayed flags, so sync and colour stay aligned.
- **Frame tick:** `frame`=1 for exactly one clk, on the `pix_en` edge where the counters move to (`h_cnt`=0, `v_cnt`=480). It is 0 at all other times.
- **Reset values** (`rst`=0 sampled at a clk edge):
  - `h_cnt`=0, `v_cnt`=0, `VGA_CLK`=0
  - `rd_addr`=0, `frame`=0
  - `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_N`=0
  - `VGA_R`/`VGA_G`/`VGA_B`=0, delay flops cleared
- **Reset mid-frame:** all state takes reset values on the next clk edge. Scan restarts at (0,0) and no `frame` pulse is emitted.
- `VGA_SYNC_N` is tied to 1 at all times, including during reset.

## Timing
- Pixel period: 2 clk.
- Line: 800 pixels = 1600 clk. Frame: 525 lines = 840000 clk, about 59.5 Hz.
- hsync low for 96 pixels = 192 clk per line.
- vsync low for 2 lines = 3200 clk per frame.
- Latency from counter value to DAC outputs: exactly 1 pixel period (2 clk). It is identical for colour, blank and sync.
- RAM contract: registered read, data valid exactly 1 clk after the address changes.
- First `pix_en` after reset release: the second clk edge (`VGA_CLK` goes 0->1, then 1->0).
- Simultaneous `h_cnt` and `v_cnt` wrap (799,524 -> 0,0): single edge, no glitch on any output.

## Configuration
- `VGA_SCANOUT_BORDER_EN`
  - **Defined:** when logical x∈{0,159} or y∈{0,119} and visible, the output colour is forced to 3'b111 and `rd_data` is ignored. This gives a debug playfield outline.
  - **Undefined:** colour always comes from `rd_data`. Border logic is absent from the netlist.

## Test plan
- **Reset:** hold `rst`=0 for 5 clk, release. Required:
  - outputs at reset values during reset
  - `VGA_CLK` toggles from the first edge after release
  - `VGA_BLANK_N` rises 2 clk after the first `pix_en` edge
- **Line and frame timing:** run 2 frames. Required:
  - `VGA_HS` low 192 clk out of every 1600
  - `VGA_VS` low 3200 clk out of every 840000
  - `frame` pulses exactly twice, 840000 clk apart, each 1 clk wide
- **Addressing:** at `h_cnt`=8..11 and `v_cnt`=4..7, `rd_addr`=162. At `h_cnt`=636, `v_cnt`=476, `rd_addr`=19199. Addresses stay <19200 at all times.
- **Colour and blanking:**
  - RAM model returns 3'b101 for all addresses: visible pixels show R=10'h3FF, G=0, B=10'h3FF.
  - During `h_cnt` 640..799, RGB=0 even though `rd_data`=3'b101.
- **Reset mid-frame:** assert `rst`=0 for 1 clk at `v_cnt`=300. Required:
  - next edge: reset values
  - no `frame` pulse
  - the next `frame` pulse is 480*1600 clk after scan restart, plus the first-`pix_en` offset
- **With `VGA_SCANOUT_BORDER_EN`:** `rd_data`=3'b000 everywhere. Required: RGB all-ones on screen rows 0..3 and 476..479 and on columns 0..3 and 636..639; zero elsewhere in the visible area.

Source files
------------

// File: rtl/vga_scanout_if.sv
// Framebuffer read port shared by vga_scanout (master) and the framebuffer RAM (slave).
interface vga_scanout_if;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;

    // Read contract: no valid/ready pair. The master presents rd_addr and the slave
    // returns its registered read on rd_data exactly one clk later. The read is never refused.
    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/vga_scanout.sv
// 640x480 VGA scanout of the 160x120 framebuffer with 4x4 pixel replication and a per-frame tick.
// Optional build macro VGA_SCANOUT_BORDER_EN forces a white outline around the playfield.
module vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic          clk,
    input  logic          rst,
    vga_scanout_if.master fb,
    output logic          frame,
    output logic          VGA_CLK,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic [9:0]    VGA_R,
    output logic [9:0]    VGA_G,
    output logic [9:0]    VGA_B
);
    localparam logic [9:0] H_MAX    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_MAX    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
    localparam logic [9:0] V_LAST   = 10'(V_VIS - 1);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic        pix_en;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        visible;
    logic        hs_n;
    logic        vs_n;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] addr;
    logic        vis_d;
    logic        hs_d;
    logic        vs_d;
    logic [2:0]  colour;

    // Pixel logic advances on the clk edge where VGA_CLK falls.
    assign pix_en = VGA_CLK;

    assign visible = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);
    assign hs_n    = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
    assign vs_n    = !((v_cnt >= VS_START) && (v_cnt <= VS_END));

    // y*160 + x built as y*128 + y*32 + x.
    assign x    = h_cnt[9:2];
    assign y    = v_cnt[8:2];
    assign addr = {1'b0, y, 7'd0} + {3'd0, y, 5'd0} + {7'd0, x};

`ifdef VGA_SCANOUT_BORDER_EN
    logic border_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            border_d <= 1'b0;
        end else if (pix_en) begin
            border_d <= visible && ((x == 8'd0) || (x == 8'd159) || (y == 7'd0) || (y == 7'd119));
        end
    end

    assign colour = border_d ? 3'b111 : fb.rd_data;
`else
    assign colour = fb.rd_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            VGA_CLK     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            fb.rd_addr  <= '0;
            frame       <= 1'b0;
            vis_d       <= 1'b0;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            VGA_CLK <= ~VGA_CLK;
            frame   <= 1'b0;
            if (pix_en) begin
                if (h_cnt == H_MAX) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
                    frame <= (v_cnt == V_LAST);
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
                if (visible) begin
                    fb.rd_addr <= addr;
                end
                vis_d <= visible;
                hs_d  <= hs_n;
                vs_d  <= vs_n;
                // Second stage: RAM data for the address issued one pixel ago lines up with the delayed flags.
                VGA_BLANK_N <= vis_d;
                VGA_HS      <= hs_d;
                VGA_VS      <= vs_d;
                VGA_R       <= vis_d ? {10{colour[2]}} : 10'd0;
                VGA_G       <= vis_d ? {10{colour[1]}} : 10'd0;
                VGA_B       <= vis_d ? {10{colour[0]}} : 10'd0;
            end
        end
    end

    assign VGA_SYNC_N = 1'b1;
endmodule
